// File: rtl/seq_divider_32.sv
// ---------------------------------------------------------------------------
// seq_divider_32
//   Multi-cycle restoring divider for MIPS div/divu. It runs beside the ALU
//   in the execute stage. The divider handles operand magnitudes, performing
//   one shift-subtract step per clock. A final fix-up cycle restores the signs
//   and handles a zero divisor. Latency is fixed at WIDTH+1 cycles from the
//   start edge to the done pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (aborts any operation)
//   start        request, sampled only while idle
//   signed_op    1 = div (two's complement), 0 = divu; sampled with start
//   dividend     rs operand, sampled with start
//   divisor      rt operand, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse; results valid in that cycle
//   quotient     LO result, held until the next completion or reset
//   remainder    HI result, held until the next completion or reset
//   div_by_zero  divisor was zero for the last completed operation
// ---------------------------------------------------------------------------
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    step_cnt;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] work_quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_orig;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0]        shifted;
    logic signed [WIDTH:0]   trial;
    logic                    trial_ok;

    // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an
    // unsigned value, which is why the signed overflow case needs no flag.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        if (is_signed && x[WIDTH-1])
            return -x;
        return x;
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x,
                                                   input logic             neg);
        if (neg)
            return -x;
        return x;
    endfunction

    // Shift-subtract step. The top bit of part_rem is dropped by the shift. It
    // can only be set after the last step, so the shifted value always fits.
    always_comb begin
        shifted  = {part_rem[WIDTH-2:0], work_quo[WIDTH-1]};
        trial    = $signed({1'b0, shifted}) - $signed({1'b0, dvs_mag});
        trial_ok = ~trial[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (step_cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt    <= '0;
            part_rem    <= '0;
            work_quo    <= '0;
            dvs_mag     <= '0;
            dvd_orig    <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // Operand capture; magnitudes are taken here so the iteration is unsigned
                IDLE: begin
                    if (start) begin
                        step_cnt <= '0;
                        part_rem <= '0;
                        work_quo <= magnitude(dividend, signed_op);
                        dvs_mag  <= magnitude(divisor, signed_op);
                        dvd_orig <= dividend;
                        neg_quo  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem  <= signed_op & dividend[WIDTH-1];
                    end
                end
                // Iteration: one quotient bit per clock
                RUN: begin
                    step_cnt <= step_cnt + CW'(1);
                    if (trial_ok) begin
                        part_rem <= trial[WIDTH-1:0];
                        work_quo <= {work_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        part_rem <= shifted;
                        work_quo <= {work_quo[WIDTH-2:0], 1'b0};
                    end
                end
                // Sign restoration and zero-divisor handling
                FIX: begin
                    done <= 1'b1;
                    if (dvs_mag == '0) begin
                        quotient    <= '1;
                        remainder   <= dvd_orig;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= negate_if(work_quo, neg_quo);
                        remainder   <= negate_if(part_rem, neg_rem);
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
